vga_fb_arbiter: RTL

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: display reads always win; posted pixel writes (small FIFO)
// and a full-frame clear engine share the remaining non-display cycles.
module vga_fb_arbiter #(
    parameter int H_DISP     = 800,
    parameter int V_DISP     = 600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_vga_driver,
    input  logic        rst_n_driver,
    input  logic        nxt_active,
    input  logic [11:0] nxt_x,
    input  logic [11:0] nxt_y,
    input  logic        wr_req,
    input  logic [18:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic        fifo_full,
    input  logic        clear_req,
    input  logic [15:0] clear_color,
    output logic        clear_busy,
    output logic [18:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    output logic [15:0] data_vga_driver
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [18:0]   LAST_ADDR = 19'(H_DISP * V_DISP - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [11:0]   H_LIM     = 12'(H_DISP);
    localparam logic [11:0]   V_LIM     = 12'(V_DISP);

    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

    // y*800 + x built from shifts (512 + 256 + 32), truncated to the RAM width
    function automatic logic [18:0] pix_addr(input logic [11:0] x, input logic [11:0] y);
        logic [23:0] a;
        a = ({12'd0, y} << 9) + ({12'd0, y} << 8) + ({12'd0, y} << 5) + {12'd0, x};
        return a[18:0];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    state_t        state_r, state_next_s;
    logic [34:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_next_s;
    logic          fifo_full_r, wr_ack_r, clear_busy_r, clear_pend_r, rd_pend_r;
    logic [15:0]   clear_color_r;
    logic [18:0]   clr_addr_r;
    logic          display_s, push_s, pop_s, clr_step_s, clear_acc_s, latch_s, take_pend_s;
    logic          ram_we_s;
    logic [18:0]   ram_addr_s;
    logic [15:0]   ram_wdata_s;
    logic [34:0]   head_s;

    assign display_s   = nxt_active && (nxt_x < H_LIM) && (nxt_y < V_LIM);
    assign push_s      = wr_req && !fifo_full_r && !clear_busy_r && !wr_ack_r;
    assign clear_acc_s = clear_req && !clear_busy_r && !clear_pend_r;
    assign head_s      = mem_r[rd_ptr_r];

    // Bus arbitration and next-state selection; the FSM only advances in non-display cycles
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        clr_step_s   = 1'b0;
        latch_s      = 1'b0;
        take_pend_s  = 1'b0;
        ram_we_s     = 1'b0;
        ram_addr_s   = 19'd0;
        ram_wdata_s  = 16'd0;
        if (display_s) begin
            ram_addr_s = pix_addr(nxt_x, nxt_y);
            latch_s    = clear_acc_s;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear_pend_r) begin
                        take_pend_s  = 1'b1;
                        state_next_s = CLEAR;
                    end else if (clear_acc_s) begin
                        state_next_s = CLEAR;
                    end else if (count_r != '0) begin
                        pop_s        = 1'b1;
                        ram_we_s     = 1'b1;
                        ram_addr_s   = head_s[34:16];
                        ram_wdata_s  = head_s[15:0];
                        state_next_s = (count_r == ONE_C && !push_s) ? IDLE : DRAIN;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                DRAIN: begin
                    latch_s = clear_acc_s;
                    if (count_r != '0) begin
                        pop_s        = 1'b1;
                        ram_we_s     = 1'b1;
                        ram_addr_s   = head_s[34:16];
                        ram_wdata_s  = head_s[15:0];
                        state_next_s = (count_r == ONE_C && !push_s) ? IDLE : DRAIN;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CLEAR: begin
                    clr_step_s   = 1'b1;
                    ram_we_s     = 1'b1;
                    ram_addr_s   = clr_addr_r;
                    ram_wdata_s  = clear_color_r;
                    state_next_s = (clr_addr_r == LAST_ADDR) ? IDLE : CLEAR;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end

        if (push_s && !pop_s) begin
            count_next_s = count_r + ONE_C;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - ONE_C;
        end else begin
            count_next_s = count_r;
        end
    end

    // Control state, FIFO pointers, clear engine and display-read tracking
    always_ff @(posedge clk_vga_driver or negedge rst_n_driver) begin
        if (!rst_n_driver) begin
            state_r       <= IDLE;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            fifo_full_r   <= 1'b0;
            wr_ack_r      <= 1'b0;
            clear_busy_r  <= 1'b0;
            clear_pend_r  <= 1'b0;
            clear_color_r <= 16'd0;
            clr_addr_r    <= 19'd0;
            rd_pend_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            fifo_full_r  <= (count_next_s == DEPTH_C);
            wr_ack_r     <= push_s;
            clear_busy_r <= (state_next_s == CLEAR);
            rd_pend_r    <= display_s;
            if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            if (latch_s) clear_pend_r <= 1'b1;
            else if (take_pend_s) clear_pend_r <= 1'b0;
            if (clear_acc_s) clear_color_r <= clear_color;
            if (clr_step_s) clr_addr_r <= (clr_addr_r == LAST_ADDR) ? 19'd0 : clr_addr_r + 19'd1;
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk_vga_driver) begin
        if (push_s) mem_r[wr_ptr_r] <= {wr_addr, wr_data};
    end

    assign wr_ack          = wr_ack_r;
    assign fifo_full       = fifo_full_r;
    assign clear_busy      = clear_busy_r;
    assign ram_we          = ram_we_s;
    assign ram_addr        = ram_addr_s;
    assign ram_wdata       = ram_wdata_s;
    assign data_vga_driver = rd_pend_r ? ram_rdata : 16'h0000;
endmodule
